change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 200, cycles to wait for eject_ack before fault.
REQ-002 SHALL have parameter GAP_CYCLES, default 4, idle cycles between consecutive coin ejects.
REQ-003 SHALL have parameter INV_W, default 6, width of each coin inventory counter.
REQ-004 SHALL have one clock; reset is asynchronous and active-low. Ports are clock and reset.
REQ-005 clock  input  1  system clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 change_req  input  1  one-cycle request; sample change_code in the same cycle.
REQ-008 change_code  input  3  000 zero, 001 nickel, 010 dime, 011 nickel_dime, 100 dime_dime, 101 quarter; 110 and 111 are invalid.
REQ-009 eject_ack  input  1  coin mechanism confirms the current coin dropped.
REQ-010 refill_nickel, refill_dime, refill_quarter  input  1 each  one-cycle pulse adds one coin to that inventory.
REQ-011 clear_fault  input  1  returns the block from FAULT to IDLE.
REQ-012 eject_nickel, eject_dime, eject_quarter  output  1 each  one-hot coin eject command.
REQ-013 busy  output  1  high in every state except IDLE and FAULT.
REQ-014 done  output  1  one-cycle pulse when the full amount has been dispensed.
REQ-015 bad_code  output  1  one-cycle pulse when a request carries an invalid code.
REQ-016 fault  output  1  high while in FAULT.
REQ-017 remaining  output  3  amount still owed, in 5-cent units.
REQ-018 nickel_inv, dime_inv, quarter_inv  output  INV_W each  current coin counts.

Function
REQ-019 FSM states SHALL be IDLE, SELECT, EJECT, GAP, DONE, FAULT.
REQ-020 IDLE: a change_req with a valid nonzero code SHALL load remaining (code value 0..5) and go to SELECT next cycle.
REQ-021 IDLE: change_req with code 000 SHALL pulse done next cycle and dispense nothing.
REQ-022 IDLE: change_req with code 110 or 111 SHALL pulse bad_code next cycle and stay in IDLE.
REQ-023 change_req outside IDLE SHALL be ignored.
REQ-024 SELECT SHALL choose greedily, first match wins:
- remaining>=5 and quarter_inv>0: quarter.
- remaining>=2 and dime_inv>0: dime.
- remaining>=1 and nickel_inv>0: nickel.
- none of the above: go to FAULT.
REQ-025 A missing dime SHALL be substituted with two nickels through repeated SELECT passes.
REQ-026 EJECT SHALL hold exactly one eject_* high until eject_ack is sampled high.
REQ-027 On that ack the block SHALL, in the same edge:
- drop eject_*;
- subtract the coin value from remaining;
- decrement that coin's inventory;
- go to GAP.
REQ-028 EJECT SHALL go to FAULT if no ack arrives within ACK_TIMEOUT cycles; remaining and inventory SHALL not change.
REQ-029 GAP SHALL last GAP_CYCLES cycles, then go to DONE if remaining==0, else to SELECT.
REQ-030 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-031 FAULT SHALL hold remaining; clear_fault SHALL zero remaining and go to IDLE next cycle.
REQ-032 A refill pulse SHALL increment its inventory and saturate at 2^INV_W-1.
REQ-033 A refill and a decrement of the same coin in the same cycle SHALL leave that count unchanged.
REQ-034 eject_ack outside EJECT SHALL be ignored.
REQ-035 Latency for a one-coin request (ack on first EJECT cycle): request -> eject 2 cycles; ack -> done GAP_CYCLES+1 cycles.

Reset
REQ-036 While reset is low the block SHALL clear the following, immediately and asynchronously:
- state to IDLE;
- all outputs to 0;
- remaining to 0;
- all inventories to 0;
- timeout and gap counters to 0.
REQ-037 Reset mid-dispense SHALL abandon the transaction and lower eject_* without waiting for an ack.

Structure
REQ-038 A shared package SHALL hold the change-code constants (000..101), the state encoding, and the coin values in 5-cent units (nickel 1, dime 2, quarter 5).
REQ-039 A single sub-module, coin_inventory, SHALL implement one saturating up/down counter and be instantiated three times.

Verification
REQ-040 Scenario: inventories 3/3/3, request code 100, immediate acks -> exactly two eject_dime pulses, done, dime_inv=1.
REQ-041 Scenario: dime_inv=0, nickel_inv=4, request code 011 -> three eject_nickel pulses, nickel_inv=1, done.
REQ-042 Scenario: request code 101 with quarter_inv=0, dime_inv=1, nickel_inv=0 -> one dime ejected, then fault with remaining=3.
REQ-043 Scenario: withhold eject_ack for ACK_TIMEOUT cycles -> fault, inventory unchanged; clear_fault -> IDLE with remaining=0.
REQ-044 Scenario: request code 111 -> one bad_code pulse, no eject, busy stays 0; refill_nickel together with an ack of a nickel -> nickel_inv unchanged.
REQ-045 Scenario: reset asserted while in EJECT -> eject_* falls without a clock edge; after release, state is IDLE with all inventories 0.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared constants for the change dispenser.
// Change codes, FSM state encoding and coin values in 5-cent units.
package change_dispenser_pkg;

  localparam logic [2:0] CODE_ZERO        = 3'b000;
  localparam logic [2:0] CODE_NICKEL      = 3'b001;
  localparam logic [2:0] CODE_DIME        = 3'b010;
  localparam logic [2:0] CODE_NICKEL_DIME = 3'b011;
  localparam logic [2:0] CODE_DIME_DIME   = 3'b100;
  localparam logic [2:0] CODE_QUARTER     = 3'b101;

  localparam logic [2:0] VAL_NICKEL  = 3'd1;
  localparam logic [2:0] VAL_DIME    = 3'd2;
  localparam logic [2:0] VAL_QUARTER = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  // Each valid code equals the amount owed in 5-cent units.
  function automatic logic code_valid(input logic [2:0] c);
    return c <= CODE_QUARTER;
  endfunction

endpackage

// File: rtl/change_dispenser_coin_inventory.sv
// One coin inventory: saturating up/down counter.
// A simultaneous refill and eject leave the count unchanged.
module coin_inventory #(
  parameter int INV_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [INV_W-1:0] count
);

  localparam logic [INV_W-1:0] MAX = '1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && !dec && count != MAX) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: greedy coin selection, eject handshake
// with ack timeout, inter-coin gap and three coin inventories.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int ACK_TIMEOUT = 200,
  parameter int GAP_CYCLES  = 4,
  parameter int INV_W       = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             change_req,
  input  logic [2:0]       change_code,
  input  logic             eject_ack,
  input  logic             refill_nickel,
  input  logic             refill_dime,
  input  logic             refill_quarter,
  input  logic             clear_fault,
  output logic             eject_nickel,
  output logic             eject_dime,
  output logic             eject_quarter,
  output logic             busy,
  output logic             done,
  output logic             bad_code,
  output logic             fault,
  output logic [2:0]       remaining,
  output logic [INV_W-1:0] nickel_inv,
  output logic [INV_W-1:0] dime_inv,
  output logic [INV_W-1:0] quarter_inv
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;
  logic [2:0]    coin_val;
  logic          pick_q, pick_d, pick_n;
  logic          acked;

  // First match wins: later picks are masked by earlier ones.
  assign pick_q = (remaining >= VAL_QUARTER) && (quarter_inv != '0);
  assign pick_d = !pick_q && (remaining >= VAL_DIME) && (dime_inv != '0);
  assign pick_n = !pick_q && !pick_d && (remaining >= VAL_NICKEL)
                  && (nickel_inv != '0);

  assign acked = (state == S_EJECT) && eject_ack;

  always_comb begin
    coin_val = '0;
    unique case (1'b1)
      eject_quarter: coin_val = VAL_QUARTER;
      eject_dime:    coin_val = VAL_DIME;
      eject_nickel:  coin_val = VAL_NICKEL;
      default:       coin_val = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      eject_nickel  <= 1'b0;
      eject_dime    <= 1'b0;
      eject_quarter <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bad_code      <= 1'b0;
      fault         <= 1'b0;
      remaining     <= '0;
      tmo_cnt       <= '0;
      gap_cnt       <= '0;
    end else begin
      done     <= 1'b0;
      bad_code <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (change_req) begin
            if (change_code == CODE_ZERO) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b1;
            end else if (code_valid(change_code)) begin
              remaining <= change_code;
              state     <= S_SELECT;
              busy      <= 1'b1;
            end else begin
              bad_code <= 1'b1;
            end
          end
        end
        S_SELECT: begin
          tmo_cnt <= '0;
          unique case (1'b1)
            pick_q: begin
              eject_quarter <= 1'b1;
              state         <= S_EJECT;
            end
            pick_d: begin
              eject_dime <= 1'b1;
              state      <= S_EJECT;
            end
            pick_n: begin
              eject_nickel <= 1'b1;
              state        <= S_EJECT;
            end
            default: begin
              state <= S_FAULT;
              fault <= 1'b1;
              busy  <= 1'b0;
            end
          endcase
        end
        S_EJECT: begin
          if (eject_ack) begin
            remaining     <= remaining - coin_val;
            eject_nickel  <= 1'b0;
            eject_dime    <= 1'b0;
            eject_quarter <= 1'b0;
            gap_cnt       <= '0;
            state         <= S_GAP;
          end else if (tmo_cnt == TMO_LAST) begin
            eject_nickel  <= 1'b0;
            eject_dime    <= 1'b0;
            eject_quarter <= 1'b0;
            state         <= S_FAULT;
            fault         <= 1'b1;
            busy          <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (remaining == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_SELECT;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        S_FAULT: begin
          if (clear_fault) begin
            remaining <= '0;
            fault     <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  coin_inventory #(.INV_W(INV_W)) u_nickel (
    .clock (clock),
    .reset (reset),
    .inc   (refill_nickel),
    .dec   (acked && eject_nickel),
    .count (nickel_inv)
  );

  coin_inventory #(.INV_W(INV_W)) u_dime (
    .clock (clock),
    .reset (reset),
    .inc   (refill_dime),
    .dec   (acked && eject_dime),
    .count (dime_inv)
  );

  coin_inventory #(.INV_W(INV_W)) u_quarter (
    .clock (clock),
    .reset (reset),
    .inc   (refill_quarter),
    .dec   (acked && eject_quarter),
    .count (quarter_inv)
  );

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized
// transactions checked against a greedy-change reference model.
module tb_change_dispenser;

  localparam int ACK_T = 24;
  localparam int GAP   = 4;
  localparam int INV_W = 6;
  localparam int MAXI  = 63;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic change_req = 1'b0;
  logic [2:0] change_code = 3'b000;
  logic eject_ack = 1'b0;
  logic refill_nickel = 1'b0;
  logic refill_dime = 1'b0;
  logic refill_quarter = 1'b0;
  logic clear_fault = 1'b0;
  logic eject_nickel, eject_dime, eject_quarter;
  logic busy, done, bad_code, fault;
  logic [2:0] remaining;
  logic [INV_W-1:0] nickel_inv, dime_inv, quarter_inv;

  int n_checks = 0;
  int n_fail = 0;
  int m_inv[3];
  int val[3] = '{1, 2, 5};

  always #5 clock = ~clock;

  change_dispenser #(
    .ACK_TIMEOUT (ACK_T),
    .GAP_CYCLES  (GAP),
    .INV_W       (INV_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .change_req     (change_req),
    .change_code    (change_code),
    .eject_ack      (eject_ack),
    .refill_nickel  (refill_nickel),
    .refill_dime    (refill_dime),
    .refill_quarter (refill_quarter),
    .clear_fault    (clear_fault),
    .eject_nickel   (eject_nickel),
    .eject_dime     (eject_dime),
    .eject_quarter  (eject_quarter),
    .busy           (busy),
    .done           (done),
    .bad_code       (bad_code),
    .fault          (fault),
    .remaining      (remaining),
    .nickel_inv     (nickel_inv),
    .dime_inv       (dime_inv),
    .quarter_inv    (quarter_inv)
  );

  function automatic int inv_of(input int c);
    if (c == 0) return int'(nickel_inv);
    if (c == 1) return int'(dime_inv);
    return int'(quarter_inv);
  endfunction

  function automatic int coin_of();
    if (eject_quarter) return 2;
    if (eject_dime) return 1;
    if (eject_nickel) return 0;
    return -1;
  endfunction

  task automatic refill(input int n, input int d, input int q);
    for (int i = 0; i < n || i < d || i < q; i++) begin
      @(negedge clock);
      refill_nickel  = (i < n);
      refill_dime    = (i < d);
      refill_quarter = (i < q);
      if (i < n) m_inv[0] = (m_inv[0] + 1 > MAXI) ? MAXI : m_inv[0] + 1;
      if (i < d) m_inv[1] = (m_inv[1] + 1 > MAXI) ? MAXI : m_inv[1] + 1;
      if (i < q) m_inv[2] = (m_inv[2] + 1 > MAXI) ? MAXI : m_inv[2] + 1;
    end
    @(negedge clock);
    refill_nickel = 0;
    refill_dime = 0;
    refill_quarter = 0;
  endtask

  task automatic load(input int n, input int d, input int q);
    @(negedge clock);
    reset = 0;
    #2 reset = 1;
    m_inv = '{0, 0, 0};
    refill(n, d, q);
  endtask

  task automatic run_txn(input logic [2:0] code, input int dly,
                         input bit refill_ack, input string tag);
    int rem, c, cyc, first_ej, last_ack, done_cyc;
    int e_coins[$];
    int got[$];
    int inv[3];
    bit exp_fault, saw_done, saw_fault, fin, first;
    rem = int'(code);
    inv = m_inv;
    exp_fault = 0;
    first = 1;
    while (rem > 0) begin
      if (rem >= 5 && inv[2] > 0) c = 2;
      else if (rem >= 2 && inv[1] > 0) c = 1;
      else if (inv[0] > 0) c = 0;
      else begin
        exp_fault = 1;
        break;
      end
      e_coins.push_back(c);
      rem -= val[c];
      if (!(first && refill_ack)) inv[c]--;
      first = 0;
    end
    @(negedge clock);
    change_req = 1;
    change_code = code;
    @(negedge clock);
    change_req = 0;
    cyc = 0;
    first_ej = -1;
    last_ack = -1;
    done_cyc = -1;
    saw_done = 0;
    saw_fault = 0;
    fin = 0;
    while (!fin && cyc < 600) begin
      if (done) begin
        saw_done = 1;
        done_cyc = cyc;
        fin = 1;
      end else if (fault) begin
        saw_fault = 1;
        fin = 1;
      end else if (coin_of() >= 0) begin
        n_checks++;
        if ($countones({eject_nickel, eject_dime, eject_quarter}) !== 1) begin
          n_fail++;
          $display("FAIL %s onehot: got %b%b%b", tag,
                   eject_nickel, eject_dime, eject_quarter);
        end
        got.push_back(coin_of());
        if (first_ej < 0) first_ej = cyc;
        repeat (dly) begin
          @(negedge clock);
          cyc++;
        end
        n_checks++;
        if (coin_of() !== got[$]) begin
          n_fail++;
          $display("FAIL %s eject_hold: got %0d want %0d", tag, coin_of(), got[$]);
        end
        eject_ack = 1;
        if (refill_ack && got.size() == 1) begin
          refill_nickel  = (got[$] == 0);
          refill_dime    = (got[$] == 1);
          refill_quarter = (got[$] == 2);
        end
        last_ack = cyc;
        @(negedge clock);
        cyc++;
        eject_ack = 0;
        refill_nickel = 0;
        refill_dime = 0;
        refill_quarter = 0;
        n_checks++;
        if (coin_of() !== -1) begin
          n_fail++;
          $display("FAIL %s eject_drop: got coin %0d want none", tag, coin_of());
        end
        continue;
      end
      if (!fin) begin
        @(negedge clock);
        cyc++;
      end
    end
    n_checks++;
    if (!fin) begin
      n_fail++;
      $display("FAIL %s txn_timeout: no done/fault after %0d cycles", tag, cyc);
    end
    n_checks++;
    if (got.size() !== e_coins.size()) begin
      n_fail++;
      $display("FAIL %s coin_count: got %0d want %0d", tag, got.size(), e_coins.size());
    end else begin
      foreach (got[i]) begin
        n_checks++;
        if (got[i] !== e_coins[i]) begin
          n_fail++;
          $display("FAIL %s coin[%0d]: got %0d want %0d", tag, i, got[i], e_coins[i]);
        end
      end
    end
    n_checks++;
    if (saw_done !== !exp_fault || saw_fault !== exp_fault) begin
      n_fail++;
      $display("FAIL %s outcome: done=%0d fault=%0d want fault=%0d",
               tag, saw_done, saw_fault, exp_fault);
    end
    if (got.size() == 1 && e_coins.size() == 1) begin
      n_checks++;
      if (first_ej !== 1) begin
        n_fail++;
        $display("FAIL %s req_to_eject: got %0d want 1 cycles after req", tag, first_ej);
      end
    end
    if (saw_done && last_ack >= 0) begin
      n_checks++;
      if (done_cyc - last_ack !== GAP + 1) begin
        n_fail++;
        $display("FAIL %s ack_to_done: got %0d want %0d", tag, done_cyc - last_ack, GAP + 1);
      end
    end
    if (exp_fault) begin
      n_checks++;
      if (remaining !== 3'(rem)) begin
        n_fail++;
        $display("FAIL %s fault_remaining: got %0d want %0d", tag, remaining, rem);
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (inv_of(k) !== inv[k]) begin
        n_fail++;
        $display("FAIL %s inv[%0d]: got %0d want %0d", tag, k, inv_of(k), inv[k]);
      end
    end
    m_inv = inv;
    if (saw_fault) begin
      clear_fault = 1;
      @(negedge clock);
      clear_fault = 0;
      n_checks++;
      if (fault !== 0 || remaining !== 3'd0 || busy !== 0) begin
        n_fail++;
        $display("FAIL %s clear_fault: fault=%0d rem=%0d busy=%0d want 0/0/0",
                 tag, fault, remaining, busy);
      end
    end else begin
      @(negedge clock);
      n_checks++;
      if (busy !== 0 || done !== 0) begin
        n_fail++;
        $display("FAIL %s post_done: busy=%0d done=%0d want 0/0", tag, busy, done);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({eject_nickel, eject_dime, eject_quarter, busy, done, bad_code, fault} !== 7'd0
        || remaining !== 3'd0 || nickel_inv !== '0 || dime_inv !== '0
        || quarter_inv !== '0) begin
      n_fail++;
      $display("FAIL reset_state: outs=%b rem=%0d inv=%0d/%0d/%0d want all 0",
               {eject_nickel, eject_dime, eject_quarter, busy, done, bad_code, fault},
               remaining, nickel_inv, dime_inv, quarter_inv);
    end
    reset = 1;
    m_inv = '{0, 0, 0};
  endtask

  task automatic test_bad_code();
    logic [2:0] codes[2] = '{3'b110, 3'b111};
    load(1, 1, 1);
    foreach (codes[i]) begin
      @(negedge clock);
      change_req = 1;
      change_code = codes[i];
      @(negedge clock);
      change_req = 0;
      n_checks++;
      if (bad_code !== 1 || busy !== 0 || coin_of() !== -1) begin
        n_fail++;
        $display("FAIL bad_code_%0d: bad=%0d busy=%0d coin=%0d want 1/0/-1",
                 i, bad_code, busy, coin_of());
      end
      @(negedge clock);
      n_checks++;
      if (bad_code !== 0 || busy !== 0 || coin_of() !== -1) begin
        n_fail++;
        $display("FAIL bad_code_pulse_%0d: bad=%0d busy=%0d want 0/0", i, bad_code, busy);
      end
    end
  endtask

  task automatic test_zero();
    load(2, 2, 2);
    run_txn(3'b000, 0, 0, "zero_code");
  endtask

  task automatic test_dime_dime();
    load(3, 3, 3);
    run_txn(3'b100, 0, 0, "dime_dime");
  endtask

  task automatic test_nickel_sub();
    load(4, 0, 0);
    run_txn(3'b011, 0, 0, "nickel_sub");
  endtask

  task automatic test_partial_fault();
    load(0, 1, 0);
    run_txn(3'b101, 1, 0, "partial_fault");
  endtask

  task automatic test_timeout();
    int held, cyc;
    load(1, 0, 0);
    @(negedge clock);
    change_req = 1;
    change_code = 3'b001;
    @(negedge clock);
    change_req = 0;
    held = 0;
    cyc = 0;
    while (!fault && cyc < 4 * ACK_T) begin
      if (eject_nickel) held++;
      @(negedge clock);
      cyc++;
    end
    n_checks++;
    if (fault !== 1 || held !== ACK_T) begin
      n_fail++;
      $display("FAIL ack_timeout: fault=%0d held=%0d want 1/%0d", fault, held, ACK_T);
    end
    n_checks++;
    if (nickel_inv !== 6'd1 || remaining !== 3'd1 || eject_nickel !== 0) begin
      n_fail++;
      $display("FAIL timeout_hold: inv=%0d rem=%0d ej=%0d want 1/1/0",
               nickel_inv, remaining, eject_nickel);
    end
    clear_fault = 1;
    @(negedge clock);
    clear_fault = 0;
    n_checks++;
    if (fault !== 0 || remaining !== 3'd0 || busy !== 0) begin
      n_fail++;
      $display("FAIL timeout_clear: fault=%0d rem=%0d busy=%0d want 0/0/0",
               fault, remaining, busy);
    end
  endtask

  task automatic test_refill_ack();
    load(2, 0, 0);
    @(negedge clock);
    eject_ack = 1;
    @(negedge clock);
    eject_ack = 0;
    n_checks++;
    if (nickel_inv !== 6'd2 || busy !== 0) begin
      n_fail++;
      $display("FAIL idle_ack: inv=%0d busy=%0d want 2/0", nickel_inv, busy);
    end
    run_txn(3'b001, 0, 1, "refill_with_ack");
  endtask

  task automatic test_saturation();
    load(0, 0, 0);
    refill(MAXI + 3, 2, 0);
    n_checks++;
    if (nickel_inv !== 6'd63 || dime_inv !== 6'd2) begin
      n_fail++;
      $display("FAIL saturate: n=%0d d=%0d want 63/2", nickel_inv, dime_inv);
    end
  endtask

  task automatic test_random();
    load($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    for (int t = 0; t < 12; t++) begin
      refill($urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 1));
      run_txn(3'($urandom_range(0, 5)), $urandom_range(0, 3), 0, "random");
    end
  endtask

  task automatic test_reset_mid_eject();
    int cyc;
    load(2, 1, 0);
    @(negedge clock);
    change_req = 1;
    change_code = 3'b001;
    @(negedge clock);
    change_req = 0;
    cyc = 0;
    while (!eject_nickel && cyc < 10) begin
      @(negedge clock);
      cyc++;
    end
    #2 reset = 0;
    #1;
    n_checks++;
    if (eject_nickel !== 0 || busy !== 0 || nickel_inv !== '0 || dime_inv !== '0) begin
      n_fail++;
      $display("FAIL async_reset: ej=%0d busy=%0d n=%0d d=%0d want 0",
               eject_nickel, busy, nickel_inv, dime_inv);
    end
    #1 reset = 1;
    m_inv = '{0, 0, 0};
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (busy !== 0 || fault !== 0 || remaining !== 3'd0 || coin_of() !== -1
        || nickel_inv !== '0 || dime_inv !== '0 || quarter_inv !== '0) begin
      n_fail++;
      $display("FAIL after_reset: busy=%0d fault=%0d rem=%0d want idle/zero",
               busy, fault, remaining);
    end
  endtask

  initial begin
    test_reset();
    test_bad_code();
    test_zero();
    test_dime_dime();
    test_nickel_sub();
    test_partial_fault();
    test_timeout();
    test_refill_ack();
    test_saturation();
    test_random();
    test_reset_mid_eject();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
